rd_scoreboard: RTL and testbench

Parametrised register-file scoreboard for the processor's decode/writeback path. It decodes issue and writeback destination addresses into one-hot vectors and keeps a pending-write bit per architectural register. It stalls decode on RAW/WAW hazards and emits a registered one-hot write-enable for the register file. It is the sequential successor to the fixed 32-way write decoder.

---
 rtl/sb_pkg.sv | 14 +
 rtl/decoder_onehot.sv | 12 +
 rtl/rd_scoreboard.sv | 90 +++++++++
 tb/tb_rd_scoreboard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared constants for the register-file scoreboard: default address width,
// derived register/counter sizes and the hard-wired zero register index.
package sb_pkg;
   localparam int SB_ADDR_W = 5;
   localparam int SB_R0     = 0;

   function automatic int sb_nregs(input int aw);
      return 1 << aw;
   endfunction

   function automatic int sb_cnt_w(input int aw);
      return aw + 1;
   endfunction
endpackage

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder with enable: out = en << sel.
module decoder_onehot #(
   parameter int ADDR_W = 5
) (
   input  logic                     en,
   input  logic [ADDR_W-1:0]        sel,
   output logic [(1<<ADDR_W)-1:0]   out
);
   for (genvar gi = 0; gi < (1 << ADDR_W); gi++) begin : g_bit
      assign out[gi] = en & (sel == ADDR_W'(gi));
   end
endmodule

// File: rtl/rd_scoreboard.sv
// Pending-write scoreboard: stalls decode on RAW/WAW hazards and registers the
// regfile write-enable. Optional SB_WB_BYPASS_EN lets a same-cycle writeback hide its register.
module rd_scoreboard
   import sb_pkg::*;
#(
   parameter  int ADDR_W = SB_ADDR_W,
   localparam int NREGS  = sb_nregs(ADDR_W),
   localparam int CNT_W  = sb_cnt_w(ADDR_W)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rs1,
   input  logic [ADDR_W-1:0] iss_rs2,
   input  logic              iss_wr,
   input  logic [ADDR_W-1:0] iss_rd,
   output logic              iss_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic              flush,
   output logic [NREGS-1:0]  pending,
   output logic [CNT_W-1:0]  pend_cnt,
   output logic [NREGS-1:0]  wen_onehot,
   output logic              err
);
   localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(SB_R0);

   logic [NREGS-1:0] wb_vec;
   logic [NREGS-1:0] set_vec;
   logic [NREGS-1:0] clr_vec;
   logic [NREGS-1:0] eff_pending;
   logic [NREGS-1:0] pending_next;
   logic [CNT_W-1:0] cnt_next;
   logic             hazard;
   logic             fire;
   logic             set_en;
   logic             wb_hit;
   logic             clr_en;
   logic             stray_wb;
   logic             cnt_inc;
   logic             cnt_dec;

   decoder_onehot #(.ADDR_W(ADDR_W)) u_wb_dec  (.en(wb_valid), .sel(wb_rd),  .out(wb_vec));
   decoder_onehot #(.ADDR_W(ADDR_W)) u_set_dec (.en(set_en),   .sel(iss_rd), .out(set_vec));
   decoder_onehot #(.ADDR_W(ADDR_W)) u_clr_dec (.en(clr_en),   .sel(wb_rd),  .out(clr_vec));

`ifdef SB_WB_BYPASS_EN
   assign eff_pending = pending & ~wb_vec;
`else
   assign eff_pending = pending;
`endif

   assign hazard    = eff_pending[iss_rs1] | eff_pending[iss_rs2] | (iss_wr & eff_pending[iss_rd]);
   assign iss_ready = !hazard & !flush;
   assign fire      = iss_valid & iss_ready;
   assign set_en    = fire & iss_wr & (iss_rd != R0_ADDR);

   // r0 is never pending, so clr_en excludes it without an explicit test
   assign wb_hit    = pending[wb_rd];
   assign clr_en    = wb_valid & wb_hit;
   assign stray_wb  = wb_valid & !wb_hit & (wb_rd != R0_ADDR);

   // A set that lands on a bit being cleared this cycle is net zero for the count
   assign cnt_inc   = set_en & !pending[iss_rd];
   assign cnt_dec   = clr_en & !(set_en & (iss_rd == wb_rd));

   assign pending_next = (pending & ~clr_vec) | set_vec;
   assign cnt_next     = pend_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending    <= '0;
         pend_cnt   <= '0;
         wen_onehot <= '0;
         err        <= 1'b0;
      end else begin
         wen_onehot <= wb_vec;
         if (flush) begin
            pending  <= '0;
            pend_cnt <= '0;
         end else begin
            pending  <= pending_next;
            pend_cnt <= cnt_next;
            if (stray_wb) begin
               err <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rd_scoreboard.sv
// Directed bench for rd_scoreboard with a behavioural per-register model checked every cycle.
module tb_rd_scoreboard;
   logic        clock;
   logic        reset_n;
   logic        iss_valid;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic        iss_wr;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic [31:0] pending;
   logic [5:0]  pend_cnt;
   logic [31:0] wen_onehot;
   logic        err;

   rd_scoreboard dut (
      .clock(clock), .reset_n(reset_n),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .pending(pending), .pend_cnt(pend_cnt), .wen_onehot(wen_onehot), .err(err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // model state: one bit per register, sticky error, last write-enable
   logic        mp   [32];
   logic        merr;
   logic [31:0] mwen;
   int          passed = 0;
   int          total  = 0;
   int          cycle_no = 0;
   logic        bypass;

   function automatic logic [31:0] model_vec();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = mp[r];
      return v;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int r = 0; r < 32; r++) if (mp[r]) n++;
      return n;
   endfunction

   function automatic logic model_busy(input int r);
      return mp[r] && !(bypass && wb_valid && int'(wb_rd) == r);
   endfunction

   function automatic logic model_ready();
      logic h;
      h = model_busy(int'(iss_rs1)) || model_busy(int'(iss_rs2)) ||
          (iss_wr && model_busy(int'(iss_rd)));
      return !h && !flush;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_no);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) mp[r] = 1'b0;
      merr = 1'b0;
      mwen = '0;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic wr, input logic [4:0] rd,
                        input logic wbv, input logic [4:0] wbr, input logic fl);
      iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs2; iss_wr = wr; iss_rd = rd;
      wb_valid = wbv; wb_rd = wbr; flush = fl;
   endtask

   // one cycle: compare at the falling edge, then advance the model across the rising edge
   task automatic cyc();
      logic nxt [32];
      logic rdy;
      logic nerr;
      @(negedge clock);
      rdy = model_ready();
      chk("iss_ready",  64'(iss_ready),  64'(rdy));
      chk("pending",    64'(pending),    64'(model_vec()));
      chk("pend_cnt",   64'(pend_cnt),   64'(model_count()));
      chk("wen_onehot", 64'(wen_onehot), 64'(mwen));
      chk("err",        64'(err),        64'(merr));
      $display("cyc %0d: iss v=%0b rs1=%0d rs2=%0d wr=%0b rd=%0d | wb v=%0b rd=%0d | flush=%0b -> ready=%0b pend=%h cnt=%0d err=%0b",
               cycle_no, iss_valid, iss_rs1, iss_rs2, iss_wr, iss_rd, wb_valid, wb_rd,
               flush, iss_ready, pending, pend_cnt, err);
      for (int r = 0; r < 32; r++) nxt[r] = mp[r];
      nerr = merr;
      if (wb_valid && mp[wb_rd]) nxt[wb_rd] = 1'b0;
      if (iss_valid && rdy && iss_wr && iss_rd != 5'd0) nxt[iss_rd] = 1'b1;
      if (!flush && wb_valid && wb_rd != 5'd0 && !mp[wb_rd]) nerr = 1'b1;
      if (flush) for (int r = 0; r < 32; r++) nxt[r] = 1'b0;
      @(posedge clock);
      for (int r = 0; r < 32; r++) mp[r] = nxt[r];
      merr = nerr;
      mwen = wb_valid ? (32'd1 << wb_rd) : 32'd0;
      cycle_no++;
      #1;
   endtask

   initial begin
`ifdef SB_WB_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      model_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("reset_pending", 64'(pending), 64'h0);
      chk("reset_err",     64'(err),     64'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // issue r5, then a reader of r5 must stall
      drive(1, 0, 0, 1, 5, 0, 0, 0);
      cyc();
      chk("lit_pending_r5", 64'(pending), 64'h20);
      chk("lit_cnt_r5",     64'(pend_cnt), 64'd1);
      drive(1, 5, 0, 0, 0, 0, 0, 0);
      #1;
      chk("lit_ready_raw", 64'(iss_ready), 64'd0);
      cyc();

      // writeback r5 with the dependent reader presented
      drive(1, 5, 0, 0, 0, 1, 5, 0);
      #1;
      chk("lit_ready_wb_cycle", 64'(iss_ready), 64'(bypass));
      cyc();
      chk("lit_wen_r5",      64'(wen_onehot), 64'h20);
      chk("lit_pending_clr", 64'(pending),    64'h0);
      drive(1, 5, 0, 0, 0, 0, 0, 0);
      #1;
      chk("lit_ready_after_wb", 64'(iss_ready), 64'd1);
      cyc();

      // same-cycle set and clear of r7
      drive(1, 0, 0, 1, 7, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 1, 7, 1, 7, 0);
      cyc();
      chk("lit_p7_set_wins", 64'(pending[7]), 64'(bypass));
      chk("lit_cnt_r7",      64'(pend_cnt),   64'(bypass));

      // flush with a stray writeback: err must not move
      drive(0, 0, 0, 0, 0, 1, 12, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 1, 12, 1);
      cyc();
      chk("lit_err_flush", 64'(err), 64'd0);

      // fill r1..r31
      for (int r = 1; r < 32; r++) begin
         drive(1, 0, 0, 1, 5'(r), 0, 0, 0);
         cyc();
      end
      chk("lit_cnt_full",     64'(pend_cnt), 64'd31);
      chk("lit_pending_full", 64'(pending),  64'hFFFF_FFFE);
      drive(0, 0, 0, 0, 0, 1, 10, 0);
      cyc();
      drive(1, 10, 0, 0, 0, 1, 20, 0);
      cyc();
      chk("lit_cnt_29", 64'(pend_cnt), 64'd29);
      drive(1, 0, 0, 0, 0, 1, 3, 1);
      #1;
      chk("lit_ready_flush", 64'(iss_ready), 64'd0);
      cyc();
      chk("lit_pending_flushed", 64'(pending),    64'h0);
      chk("lit_cnt_flushed",     64'(pend_cnt),   64'd0);
      chk("lit_wen_flush",       64'(wen_onehot), 64'h8);

      // r0 traffic is inert, a stray writeback is sticky
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      cyc();
      chk("lit_r0_pending", 64'(pending), 64'h0);
      chk("lit_r0_err",     64'(err),     64'd0);
      chk("lit_wen_r0",     64'(wen_onehot), 64'h1);
      drive(0, 0, 0, 0, 0, 1, 9, 0);
      cyc();
      chk("lit_err_r9", 64'(err), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         cyc();
      end
      chk("lit_err_sticky", 64'(err), 64'd1);

      // three pending, then asynchronous reset between edges
      drive(1, 0, 0, 1, 2, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 1, 4, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 1, 8, 1, 0, 0);
      cyc();
      chk("lit_three_pending", 64'(pending), 64'h114);
      #2;
      reset_n = 1'b0;
      #1;
      chk("lit_async_pending", 64'(pending),    64'h0);
      chk("lit_async_cnt",     64'(pend_cnt),   64'd0);
      chk("lit_async_wen",     64'(wen_onehot), 64'h0);
      chk("lit_async_err",     64'(err),        64'd0);
      model_reset();
      reset_n = 1'b1;
      drive(1, 0, 0, 1, 3, 0, 0, 0);
      cyc();
      chk("lit_post_reset", 64'(pending), 64'h8);
      drive(0, 0, 0, 0, 0, 1, 3, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
